multi_channel_pulse_generator: RTL and testbench



---
 rtl/multi_channel_pulse_generator.sv | 138 +++++++++++++
 tb/tb_multi_channel_pulse_generator.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_pulse_generator.sv
// NUM_CH independent delay/pulse train channels with latched config.
// Define MULTI_CHANNEL_PULSE_GENERATOR_RETRIGGER_EN to let start restart a busy channel.
module multi_channel_pulse_generator #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int REP_W  = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_CH-1:0]         start,
   input  logic [NUM_CH-1:0]         stop,
   input  logic [NUM_CH*CNT_W-1:0]   delay_cycles,
   input  logic [NUM_CH*CNT_W-1:0]   pulse_width_cycles,
   input  logic [NUM_CH*REP_W-1:0]   repetition,
   output logic [NUM_CH-1:0]         pulse_out,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done,
   output logic                      pulse_led,
   output logic                      delay_led
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DELAY,
      S_PULSE
   } state_e;

   logic [NUM_CH-1:0] in_delay;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      state_e           state_q, state_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic [CNT_W-1:0] dly_q, dly_d;
      logic [CNT_W-1:0] wid_q, wid_d;
      logic [REP_W-1:0] rep_q, rep_d;
      logic [REP_W-1:0] left_q, left_d;
      logic             done_q, done_d;
      logic [CNT_W-1:0] din, pin, win;
      logic [REP_W-1:0] rin;
      logic             accept;

      assign din = delay_cycles[i*CNT_W +: CNT_W];
      assign pin = pulse_width_cycles[i*CNT_W +: CNT_W];
      assign rin = repetition[i*REP_W +: REP_W];
      assign win = (pin == '0) ? CNT_W'(1) : pin;

`ifdef MULTI_CHANNEL_PULSE_GENERATOR_RETRIGGER_EN
      assign accept = start[i] && !stop[i];
`else
      assign accept = start[i] && !stop[i] && (state_q == S_IDLE);
`endif

      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         dly_d   = dly_q;
         wid_d   = wid_q;
         rep_d   = rep_q;
         left_d  = left_q;
         done_d  = 1'b0;
         if (stop[i] && state_q != S_IDLE) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end else if (accept) begin
            dly_d  = din;
            wid_d  = win;
            rep_d  = rin;
            left_d = rin;
            if (din != '0) begin
               state_d = S_DELAY;
               cnt_d   = din;
            end else begin
               state_d = S_PULSE;
               cnt_d   = win;
            end
         end else begin
            unique case (state_q)
               S_DELAY: begin
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = S_PULSE;
                     cnt_d   = wid_q;
                  end else begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end
               end
               S_PULSE: begin
                  if (cnt_q != CNT_W'(1)) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else if (rep_q != '0 && left_q == REP_W'(1)) begin
                     state_d = S_IDLE;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     // rep_q == 0 means run forever, so the count is frozen
                     if (rep_q != '0) left_d = left_q - REP_W'(1);
                     if (dly_q != '0) begin
                        state_d = S_DELAY;
                        cnt_d   = dly_q;
                     end else begin
                        cnt_d = wid_q;
                     end
                  end
               end
               default: ;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dly_q   <= '0;
            wid_q   <= '0;
            rep_q   <= '0;
            left_q  <= '0;
            done_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            wid_q   <= wid_d;
            rep_q   <= rep_d;
            left_q  <= left_d;
            done_q  <= done_d;
         end
      end

      assign pulse_out[i] = (state_q == S_PULSE);
      assign in_delay[i]  = (state_q == S_DELAY);
      assign busy[i]      = (state_q != S_IDLE);
      assign done[i]      = done_q;
   end

   assign pulse_led = |pulse_out;
   assign delay_led = |in_delay;

endmodule

// File: tb/tb_multi_channel_pulse_generator.sv
// Randomised and directed bench for multi_channel_pulse_generator.
// Expected outputs come from an arithmetic model of each train's timeline.
module tb_multi_channel_pulse_generator;
   localparam int NUM_CH = 4;
   localparam int CNT_W  = 32;
   localparam int REP_W  = 10;

   logic                     clk = 1'b0;
   logic                     reset;
   logic [NUM_CH-1:0]        start, stop;
   logic [NUM_CH*CNT_W-1:0]  delay_cycles, pulse_width_cycles;
   logic [NUM_CH*REP_W-1:0]  repetition;
   logic [NUM_CH-1:0]        pulse_out, busy, done;
   logic                     pulse_led, delay_led;

   multi_channel_pulse_generator #(
      .NUM_CH(NUM_CH), .CNT_W(CNT_W), .REP_W(REP_W)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .delay_cycles(delay_cycles),
      .pulse_width_cycles(pulse_width_cycles),
      .repetition(repetition),
      .pulse_out(pulse_out), .busy(busy), .done(done),
      .pulse_led(pulse_led), .delay_led(delay_led)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // model: train start-relative cycle index and latched config
   bit m_act [NUM_CH];
   int m_k   [NUM_CH];
   int m_d   [NUM_CH];
   int m_w   [NUM_CH];
   int m_r   [NUM_CH];
   logic [NUM_CH-1:0] e_pulse, e_busy, e_done, e_delay;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step();
      bit retrig;
`ifdef MULTI_CHANNEL_PULSE_GENERATOR_RETRIGGER_EN
      retrig = 1'b1;
`else
      retrig = 1'b0;
`endif
      e_pulse = '0;
      e_busy  = '0;
      e_done  = '0;
      e_delay = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         int p;
         if (reset) begin
            m_act[c] = 1'b0;
            continue;
         end
         if (stop[c] && m_act[c]) begin
            m_act[c] = 1'b0;
         end else if (start[c] && !stop[c] && (!m_act[c] || retrig)) begin
            m_act[c] = 1'b1;
            m_k[c]   = 1;
            m_d[c]   = int'(delay_cycles[c*CNT_W +: CNT_W]);
            m_w[c]   = int'(pulse_width_cycles[c*CNT_W +: CNT_W]);
            if (m_w[c] == 0) m_w[c] = 1;
            m_r[c]   = int'(repetition[c*REP_W +: REP_W]);
         end else if (m_act[c]) begin
            m_k[c]++;
         end
         if (!m_act[c]) continue;
         p = m_d[c] + m_w[c];
         if (m_r[c] != 0 && m_k[c] > m_r[c] * p) begin
            m_act[c]  = 1'b0;
            e_done[c] = (m_k[c] == m_r[c] * p + 1);
            continue;
         end
         e_busy[c] = 1'b1;
         if (((m_k[c] - 1) % p) >= m_d[c]) e_pulse[c] = 1'b1;
         else e_delay[c] = 1'b1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("pulse_out", 32'(pulse_out), 32'(e_pulse));
      check("busy", 32'(busy), 32'(e_busy));
      check("done", 32'(done), 32'(e_done));
      check("pulse_led", 32'(pulse_led), 32'(|e_pulse));
      check("delay_led", 32'(delay_led), 32'(|e_delay));
   endtask

   task automatic run(input int n);
      for (int j = 0; j < n; j++) cycle();
   endtask

   task automatic cfg(input int c, input int d, input int w, input int r);
      delay_cycles[c*CNT_W +: CNT_W]       = CNT_W'(d);
      pulse_width_cycles[c*CNT_W +: CNT_W] = CNT_W'(w);
      repetition[c*REP_W +: REP_W]         = REP_W'(r);
   endtask

   task automatic kick(input logic [NUM_CH-1:0] s, input logic [NUM_CH-1:0] p);
      start = s;
      stop  = p;
      cycle();
      start = '0;
      stop  = '0;
   endtask

   initial begin
      reset = 1'b1;
      start = '0;
      stop  = '0;
      delay_cycles       = '0;
      pulse_width_cycles = '0;
      repetition         = '0;
      for (int c = 0; c < NUM_CH; c++) m_act[c] = 1'b0;
      run(2);
      reset = 1'b0;
      run(2);

      cfg(0, 3, 2, 1);
      kick(4'b0001, '0);
      run(8);

      cfg(1, 2, 1, 3);
      kick(4'b0010, '0);
      cfg(1, 7, 5, 2);
      run(14);

      cfg(2, 0, 4, 0);
      kick(4'b0100, '0);
      run(19);
      kick('0, 4'b0100);
      run(5);

      cfg(0, 1, 0, 2);
      cfg(1, 0, 3, 2);
      cfg(2, 4, 2, 1);
      cfg(3, 2, 5, 3);
      kick(4'b1111, '0);
      run(30);

      kick(4'b0010, 4'b0010);
      run(3);

      cfg(3, 1, 8, 1);
      kick(4'b1000, '0);
      run(4);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      run(2);
      kick(4'b1000, '0);
      run(12);

      cfg(0, 5, 5, 1);
      kick(4'b0001, '0);
      run(6);
      cfg(0, 1, 1, 1);
      kick(4'b0001, '0);
      run(10);

      for (int t = 0; t < 3000; t++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 7) == 0)
               cfg(c, $urandom_range(0, 6), $urandom_range(0, 5),
                   $urandom_range(0, 3));
            start[c] = ($urandom_range(0, 11) == 0);
            stop[c]  = ($urandom_range(0, 39) == 0);
         end
         reset = ($urandom_range(0, 299) == 0);
         cycle();
      end
      start = '0;
      stop  = '0;
      reset = 1'b0;
      run(4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
